// File: rtl/pixel_readout_pkg.sv
// Shared types and default geometry for the pixel readout path.
// The sensor top uses the same constants so both sides agree on bus layout.
package pixel_readout_pkg;

    localparam int DEF_NUM_PIXELS = 4;
    localparam int DEF_PIXEL_W    = 8;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_frame_buffer.sv
// Shadow and output frame registers for the readout stage.
// The shadow tracks the bus during read; the output buffer only changes on load.
module pixel_frame_buffer
    import pixel_readout_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int PIXEL_W    = DEF_PIXEL_W,
    parameter int IDX_W      = $clog2(DEF_NUM_PIXELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          capture,
    input  logic                          load,
    input  logic [NUM_PIXELS*PIXEL_W-1:0] data_in,
    input  logic [IDX_W-1:0]              index_next,
    output logic [PIXEL_W-1:0]            pixel
);

    localparam int BUS_W = NUM_PIXELS * PIXEL_W;

    logic [BUS_W-1:0]   shadow_r;
    logic [BUS_W-1:0]   outbuf_r;
    logic [BUS_W-1:0]   outbuf_next_s;
    logic [PIXEL_W-1:0] pixel_r;

    // Next output-buffer contents: swap in the shadow only on an accepted frame.
    always_comb begin
        outbuf_next_s = outbuf_r;
        if (load) begin
            outbuf_next_s = shadow_r;
        end else begin
            outbuf_next_s = outbuf_r;
        end
    end

    // Shadow follows the bus while read is high; its last value is what gets committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= {BUS_W{1'b0}};
        end else if (capture) begin
            shadow_r <= data_in;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Output buffer and the registered pixel mux, selected by the upcoming index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outbuf_r <= {BUS_W{1'b0}};
            pixel_r  <= {PIXEL_W{1'b0}};
        end else begin
            outbuf_r <= outbuf_next_s;
            pixel_r  <= outbuf_next_s[index_next*PIXEL_W +: PIXEL_W];
        end
    end

    assign pixel = pixel_r;

endmodule

// File: rtl/pixel_readout_capture.sv
// Captures one sensor frame per read phase and streams it out over valid/ready.
// A frame arriving while the previous one is still draining is dropped and counted.
module pixel_readout_capture
    import pixel_readout_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int PIXEL_W    = DEF_PIXEL_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          read,
    input  logic [NUM_PIXELS*PIXEL_W-1:0] data_in,
    input  logic                          out_ready,
    input  logic                          clear_overrun,
    output logic                          out_valid,
    output logic [PIXEL_W-1:0]            out_pixel,
    output logic [$clog2(NUM_PIXELS)-1:0] out_index,
    output logic                          out_sof,
    output logic                          out_eof,
    output logic                          busy,
    output logic                          overrun,
    output logic [CNT_W-1:0]              frame_count,
    output logic [CNT_W-1:0]              drop_count
);

    localparam int               IDX_W    = $clog2(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic               read_q_r;
    logic [IDX_W-1:0]   index_r;
    logic [IDX_W-1:0]   index_next_s;
    logic               commit_s;
    logic               handshake_s;
    logic               load_s;
    logic               drop_s;
    logic               done_s;
    logic               out_valid_r;
    logic               out_sof_r;
    logic               out_eof_r;
    logic               busy_r;
    logic               overrun_r;
    logic [CNT_W-1:0]   frame_count_r;
    logic [CNT_W-1:0]   drop_count_r;

    assign commit_s    = read_q_r & ~read;
    assign handshake_s = out_valid_r & out_ready;

    // Next state, next index and the load/drop/done events for this cycle.
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (commit_s) begin
                    load_s       = 1'b1;
                    index_next_s = {IDX_W{1'b0}};
                    state_next_s = STREAM;
                end else begin
                    index_next_s = {IDX_W{1'b0}};
                end
            end
            STREAM: begin
                if (handshake_s && (index_r == LAST_IDX)) begin
                    // Last pixel leaves this cycle, so a new frame can go straight in.
                    done_s       = 1'b1;
                    index_next_s = {IDX_W{1'b0}};
                    if (commit_s) begin
                        load_s       = 1'b1;
                        state_next_s = STREAM;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else if (handshake_s) begin
                    index_next_s = index_r + IDX_W'(1);
                    drop_s       = commit_s;
                end else begin
                    drop_s       = commit_s;
                end
            end
            default: begin
                state_next_s = IDLE;
                index_next_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // FSM state, read edge detector and the registered stream markers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            read_q_r    <= 1'b0;
            index_r     <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            read_q_r    <= read;
            index_r     <= index_next_s;
            out_valid_r <= (state_next_s == STREAM);
            out_sof_r   <= (state_next_s == STREAM) && (index_next_s == {IDX_W{1'b0}});
            out_eof_r   <= (state_next_s == STREAM) && (index_next_s == LAST_IDX);
            busy_r      <= (state_next_s == STREAM);
        end
    end

    // Frame/drop counters and sticky overrun; a drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_r <= {CNT_W{1'b0}};
            drop_count_r  <= {CNT_W{1'b0}};
            overrun_r     <= 1'b0;
        end else begin
            if (done_s) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end else begin
                drop_count_r <= drop_count_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clear_overrun) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    pixel_frame_buffer #(
        .NUM_PIXELS (NUM_PIXELS),
        .PIXEL_W    (PIXEL_W),
        .IDX_W      (IDX_W)
    ) u_frame_buffer (
        .clk        (clk),
        .reset      (reset),
        .capture    (read),
        .load       (load_s),
        .data_in    (data_in),
        .index_next (index_next_s),
        .pixel      (out_pixel)
    );

    assign out_valid   = out_valid_r;
    assign out_index   = index_r;
    assign out_sof     = out_sof_r;
    assign out_eof     = out_eof_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: single frame, backpressure, back-to-back,
// overrun, async reset and counter bounds (the latter on a narrow-counter instance).
module tb_pixel_readout_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        out_ready = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic [1:0]  out_index;
    logic        out_sof, out_eof, busy, overrun;
    logic [15:0] frame_count, drop_count;

    logic        s_read = 1'b0;
    logic [31:0] s_data = 32'h0403_0201;
    logic        s_ready = 1'b0;
    logic        s_clear = 1'b0;
    logic        s_valid;
    logic [7:0]  s_pixel;
    logic [1:0]  s_index;
    logic        s_sof, s_eof, s_busy, s_overrun;
    logic [3:0]  s_frames, s_drops;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    localparam logic [31:0] FA = 32'hDDCC_BBAA;
    localparam logic [31:0] FB = 32'h4433_2211;
    localparam logic [31:0] FR = 32'h0D0C_0B0A;

    always #5 clk = ~clk;

    pixel_readout_capture dut (
        .clk(clk), .reset(reset), .read(read), .data_in(data_in),
        .out_ready(out_ready), .clear_overrun(clear_overrun),
        .out_valid(out_valid), .out_pixel(out_pixel), .out_index(out_index),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .overrun(overrun),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    pixel_readout_capture #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .read(s_read), .data_in(s_data),
        .out_ready(s_ready), .clear_overrun(s_clear),
        .out_valid(s_valid), .out_pixel(s_pixel), .out_index(s_index),
        .out_sof(s_sof), .out_eof(s_eof), .busy(s_busy), .overrun(s_overrun),
        .frame_count(s_frames), .drop_count(s_drops)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input logic [31:0] f, input int i);
        return f[i*8 +: 8];
    endfunction

    task automatic check_px(input string tag, input logic [31:0] f, input int idx);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pixel"}, 32'(out_pixel), 32'(pix_of(f, idx)));
        check({tag, "_index"}, 32'(out_index), 32'(idx));
        check({tag, "_sof"},   32'(out_sof),   32'(idx == 0));
        check({tag, "_eof"},   32'(out_eof),   32'(idx == 3));
    endtask

    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int idx;
    int hs;

    initial begin
        // reset values
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sof", 32'(out_sof), 32'd0);
        check("rst_eof", 32'(out_eof), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_pixel", 32'(out_pixel), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single frame, ready always high
        out_ready = 1'b1; read = 1'b1; data_in = FA;
        repeat (3) tick();
        read = 1'b0;
        check("t1_valid_pre", 32'(out_valid), 32'd0);
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_px("t1", FA, i);
            tick();
        end
        exp_frames++;
        check("t1_valid_post", 32'(out_valid), 32'd0);
        check("t1_busy_post", 32'(busy), 32'd0);
        check("t1_frames", 32'(frame_count), 32'(exp_frames));

        // backpressure
        read = 1'b1; data_in = FA; out_ready = 1'b0;
        repeat (3) tick();
        read = 1'b0;
        tick();
        idx = 0; hs = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            check_px("t2", FA, idx);
            if (out_valid && out_ready) hs++;
            tick();
            if (pat[i] == 1) idx++;
        end
        exp_frames++;
        check("t2_handshakes", 32'(hs), 32'd4);
        check("t2_valid_post", 32'(out_valid), 32'd0);
        check("t2_frames", 32'(frame_count), 32'(exp_frames));

        // back-to-back: second read falls on the last-pixel handshake
        out_ready = 1'b1; read = 1'b1; data_in = FA;
        repeat (2) tick();
        read = 1'b0;
        tick();
        read = 1'b1; data_in = FB;
        for (int i = 0; i < 4; i++) begin
            check_px("t3a", FA, i);
            if (i == 3) read = 1'b0;
            tick();
        end
        exp_frames++;
        check_px("t3b", FB, 0);
        check("t3_overrun", 32'(overrun), 32'd0);
        check("t3_frames_mid", 32'(frame_count), 32'(exp_frames));
        for (int i = 1; i < 4; i++) begin
            tick();
            check_px("t3b", FB, i);
        end
        tick();
        exp_frames++;
        check("t3_valid_post", 32'(out_valid), 32'd0);
        check("t3_frames", 32'(frame_count), 32'(exp_frames));

        // overrun: second frame falls while index=1 and ready=0
        read = 1'b1; data_in = FA;
        tick();
        read = 1'b0;
        tick();
        read = 1'b1; data_in = 32'h9988_7766;
        tick();
        out_ready = 1'b0;
        tick();
        read = 1'b0;
        tick();
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_drops", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_px("t4", FA, i);
            tick();
        end
        exp_frames++;
        check("t4_frames", 32'(frame_count), 32'(exp_frames));
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("t4_cleared", 32'(overrun), 32'd0);
        // drop and clear in the same cycle: set wins
        read = 1'b1; data_in = FA;
        tick();
        read = 1'b0;
        tick();
        out_ready = 1'b0; read = 1'b1; data_in = 32'h5555_5555;
        tick();
        read = 1'b0; clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("t4_set_wins", 32'(overrun), 32'd1);
        check("t4_drops2", 32'(drop_count), 32'd2);
        check_px("t4c", FA, 0);
        out_ready = 1'b1;
        repeat (4) tick();
        exp_frames++;
        check("t4_frames2", 32'(frame_count), 32'(exp_frames));

        // async reset during STREAM at index 2 with read high
        read = 1'b1; data_in = FA;
        tick();
        read = 1'b0;
        tick();
        repeat (2) tick();
        out_ready = 1'b0;
        check_px("t5_pre", FA, 2);
        read = 1'b1; data_in = 32'h0102_0304;
        tick();
        reset = 1'b1;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_pixel", 32'(out_pixel), 32'd0);
        check("t5_index", 32'(out_index), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_frames", 32'(frame_count), 32'd0);
        check("t5_drops", 32'(drop_count), 32'd0);
        data_in = 32'h0506_0708;
        repeat (2) tick();
        reset = 1'b0; data_in = FR; out_ready = 1'b1;
        exp_frames = 0;
        check("t5_valid_rel", 32'(out_valid), 32'd0);
        repeat (2) tick();
        check("t5_no_stale", 32'(out_valid), 32'd0);
        read = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_px("t5", FR, i);
            tick();
        end
        exp_frames++;
        check("t5_frames_post", 32'(frame_count), 32'(exp_frames));

        // counter bounds on the 4-bit counter instance
        s_ready = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            s_read = 1'b1;
            tick();
            s_read = 1'b0;
            tick();
            repeat (4) tick();
            if (f == 15) check("t6_frames_15", 32'(s_frames), 32'd15);
        end
        check("t6_frames_wrap", 32'(s_frames), 32'd0);
        s_read = 1'b1;
        tick();
        s_read = 1'b0;
        tick();
        s_ready = 1'b0;
        for (int d = 1; d <= 17; d++) begin
            s_read = 1'b1;
            tick();
            s_read = 1'b0;
            tick();
            if (d == 14) check("t6_drops_14", 32'(s_drops), 32'd14);
        end
        check("t6_drops_sat", 32'(s_drops), 32'd15);
        check("t6_overrun", 32'(s_overrun), 32'd1);
        check("t6_valid", 32'(s_valid), 32'd1);
        check("t6_busy", 32'(s_busy), 32'd1);
        check("t6_pixel", 32'(s_pixel), 32'h01);
        check("t6_index", 32'(s_index), 32'd0);
        check("t6_sof", 32'(s_sof), 32'd1);
        check("t6_eof", 32'(s_eof), 32'd0);
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        check("t6_cleared", 32'(s_overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_readout_capture.md
Name: pixel_readout_capture

Overview:
- Downstream stage of the digital pixel sensor top. Monitors the sensor's shared data bus and its read phase.
- Captures one frame of NUM_PIXELS pixel codes at the end of each read phase.
- Streams the captured pixels out one per cycle over a valid/ready interface, with start/end-of-frame markers.
- Double-buffered (shadow + output) so one frame can be captured while the previous one drains. Reports frame count and overrun.

Parameters:
- NUM_PIXELS, 4, pixels per frame (one lane each on the data bus)
- PIXEL_W, 8, bits per pixel code
- CNT_W, 16, width of frame_count and drop_count

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- read  input  1  sensor read-phase strobe; bus content valid while high
- data_in  input  NUM_PIXELS*PIXEL_W  sensor data bus; pixel i = data_in[i*PIXEL_W +: PIXEL_W]
- out_ready  input  1  downstream ready
- clear_overrun  input  1  single-cycle clear of the sticky overrun flag
- out_valid  output  1  out_pixel valid
- out_pixel  output  PIXEL_W  current pixel code
- out_index  output  $clog2(NUM_PIXELS)  index of out_pixel within the frame
- out_sof  output  1  high with index 0
- out_eof  output  1  high with index NUM_PIXELS-1
- busy  output  1  high while in STREAM
- overrun  output  1  sticky: a frame was dropped
- frame_count  output  CNT_W  frames fully streamed, wraps
- drop_count  output  CNT_W  frames dropped, saturates at all-ones

Behaviour:
- Reset (async, active-high) values:
  - out_valid, out_sof, out_eof, busy, overrun = 0
  - out_pixel = 0, out_index = 0
  - frame_count, drop_count = 0
  - read_q = 0; shadow and output buffers = 0
  - state = IDLE
- Shadow capture: every cycle read=1, shadow <= data_in. The last sampled value (the read phase's final cycle) is the one committed.
- Commit event: read_q=1 and read=0 (falling edge of read, registered). read_q <= read each cycle.
  - Reset mid-read: read_q=0 after reset, so no commit occurs unless read is sampled high at least one cycle after reset. No partial frame from before reset is ever emitted.
- FSM IDLE:
  - out_valid=0.
  - On commit: output buffer <= shadow, index <= 0, go to STREAM. out_valid rises the cycle after the commit (latency 1 from the read fall).
- FSM STREAM:
  - out_valid=1; out_pixel = outbuf[index].
  - out_valid=1 with out_ready=0: hold out_pixel and index stable (AXI-style; valid never drops without a handshake).
  - Handshake (out_valid & out_ready) with index < NUM_PIXELS-1: index+1.
  - Handshake at index = NUM_PIXELS-1: frame_count+1 (wraps at 2^CNT_W); go to IDLE unless a simultaneous commit occurs.
- Simultaneous commit and last-pixel handshake: load the new frame, index <= 0, stay in STREAM, out_valid stays high (back-to-back, no bubble, no overrun).
- Commit in STREAM other than on the last-pixel handshake:
  - New frame dropped; output buffer untouched.
  - overrun <= 1; drop_count+1, saturating.
- overrun clears only on clear_overrun. If clear_overrun and a drop occur in the same cycle, set wins.
- busy = (state == STREAM).
- The block never drives data_in; the bus is tri-stated toward it only during read. data_in is ignored while read=0.

Decomposition:
- Package pixel_readout_pkg: state enum (IDLE, STREAM); default PIXEL_W/NUM_PIXELS constants shared with the sensor top.
- One natural sub-module: pixel_frame_buffer (shadow + output registers, load/commit, indexed read mux).
- FSM, counters and handshake stay in the top.

Test Plan:
- Single frame: read high 3 cycles with data_in=32'hDDCC_BBAA, then low; out_ready=1 -> out_valid the cycle after read falls; pixels AA, BB, CC, DD at indices 0..3; sof on AA, eof on DD; frame_count=1; busy drops after DD.
- Backpressure: same frame, out_ready toggling 1,0,0,1,1,0,1 -> each pixel held stable while ready=0; order unchanged; exactly 4 handshakes; frame_count=1.
- Back-to-back: second read fall coincides with DD handshake (data 32'h4433_2211) -> 11 follows DD with no bubble; overrun=0; frame_count=2.
- Overrun: second read falls while index=1, out_ready=0 -> frame dropped; first frame completes intact; overrun=1; drop_count=1; clear_overrun pulse -> overrun=0; a same-cycle drop+clear leaves overrun=1.
- Reset mid-operation: assert reset during STREAM at index 2 and during read high -> all outputs 0 immediately (async); read still high then falling after release commits only data sampled after reset; no stale pixels.
- Counter bounds: force 2^16 completed frames -> frame_count wraps to 0; 2^16+1 drops -> drop_count holds 16'hFFFF.
